// File: rtl/kt_pkg.sv
// Shared types and widths for the kitchen-timer button debouncer.
// Contents: debounce FSM state encoding, counter widths, saturating increment.
package kt_pkg;

  localparam int unsigned SCNT_W = 4;
  localparam int unsigned RCNT_W = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    PRESS_CHK = 2'b01,
    PRESSED   = 2'b11,
    REL_CHK   = 2'b10
  } db_state_t;

  // Sample counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [SCNT_W-1:0] scnt_sat_inc(input logic [SCNT_W-1:0] v);
    return (v == '1) ? v : SCNT_W'(v + SCNT_W'(1));
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, polarity normalisation,
// press/release qualification FSM with saturating sample counter, and an
// optional hold-to-repeat counter (elaborated only when REPEAT_EN = 1; the
// top sets REPEAT_EN from macro BUTTON_DEBOUNCER_AUTO_REPEAT_EN).
// Ports:
//   clk, res    - clock, synchronous active-high reset
//   tick        - one-cycle debounce sample strobe
//   half_tick   - one-cycle 0.5 s strobe (repeat timing)
//   btn         - raw asynchronous button
//   press_evt   - combinational, high in the strobe cycle completing a press
//   repeat_evt  - combinational, high in the half_tick cycle issuing a repeat
module debounce_channel
  import kt_pkg::*;
#(
  parameter int unsigned STABLE_SAMPLES = 3,
  parameter int unsigned REPEAT_DELAY   = 2,
  parameter bit          ACTIVE_LOW     = 1'b1,
  parameter bit          REPEAT_EN      = 1'b0
) (
  input  logic clk,
  input  logic res,
  input  logic tick,
  input  logic half_tick,
  input  logic btn,
  output logic press_evt,
  output logic repeat_evt
);

  localparam logic              REL_LVL  = ACTIVE_LOW;
  localparam logic [SCNT_W-1:0] SCNT_LIM = SCNT_W'(STABLE_SAMPLES);

  logic              sync1, sync2;
  logic              sample;
  db_state_t         state, state_n;
  logic [SCNT_W-1:0] scnt, scnt_n, scnt_inc;

  // Synchroniser; reset loads the released level so no false press appears.
  always_ff @(posedge clk) begin
    if (res) begin
      sync1 <= REL_LVL;
      sync2 <= REL_LVL;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // 1 = pressed regardless of board polarity.
  assign sample   = sync2 ^ ACTIVE_LOW;
  assign scnt_inc = scnt_sat_inc(scnt);

  // State and sample counter register.
  always_ff @(posedge clk) begin
    if (res) begin
      state <= IDLE;
      scnt  <= '0;
    end else begin
      state <= state_n;
      scnt  <= scnt_n;
    end
  end

  // Qualification FSM; only advances on the sample strobe.
  always_comb begin
    state_n   = state;
    scnt_n    = scnt;
    press_evt = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (sample) begin
            state_n = PRESS_CHK;
            scnt_n  = SCNT_W'(1);
          end
        end
        PRESS_CHK: begin
          if (sample) begin
            scnt_n = scnt_inc;
            if (scnt_inc >= SCNT_LIM) begin
              state_n   = PRESSED;
              press_evt = 1'b1;
            end
          end else begin
            state_n = IDLE;
            scnt_n  = '0;
          end
        end
        PRESSED: begin
          if (!sample) begin
            state_n = REL_CHK;
            scnt_n  = SCNT_W'(1);
          end
        end
        REL_CHK: begin
          if (!sample) begin
            scnt_n = scnt_inc;
            if (scnt_inc >= SCNT_LIM) begin
              state_n = IDLE;
              scnt_n  = '0;
            end
          end else begin
            // Release bounce: back to held without a new press event.
            state_n = PRESSED;
          end
        end
        default: begin
          state_n = IDLE;
          scnt_n  = '0;
        end
      endcase
    end
  end

  if (REPEAT_EN) begin : g_rep
    localparam logic [RCNT_W-1:0] RCNT_LIM = RCNT_W'(REPEAT_DELAY);

    logic [RCNT_W-1:0] rcnt, rcnt_n;
    logic              enter_pressed, enter_rel;

    assign enter_pressed = (state != PRESSED) && (state_n == PRESSED);
    assign enter_rel     = (state != REL_CHK) && (state_n == REL_CHK);

    // Count half-second ticks of hold, then repeat on every further tick.
    always_comb begin
      rcnt_n     = rcnt;
      repeat_evt = 1'b0;
      if ((state == PRESSED) && half_tick) begin
        if (rcnt < RCNT_LIM) begin
          rcnt_n = RCNT_W'(rcnt + RCNT_W'(1));
        end else if (rcnt == RCNT_LIM) begin
          repeat_evt = 1'b1;
        end
      end
      if (enter_pressed || enter_rel) begin
        rcnt_n = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (res) rcnt <= '0;
      else     rcnt <= rcnt_n;
    end
  end else begin : g_norep
    logic unused_rep;
    assign unused_rep = ^{half_tick, RCNT_W'(REPEAT_DELAY)};
    assign repeat_evt = 1'b0;
  end

endmodule

// File: rtl/button_debouncer.sv
// Kitchen-timer push-button conditioner: five debounced channels, START/STOP
// priority, UP_DOWN toggle and registered one-cycle press pulses.
// Optional feature: define BUTTON_DEBOUNCER_AUTO_REPEAT_EN to enable
// hold-to-repeat on the M and S channels.
// Ports:
//   CLK, RES                 - clock, synchronous active-high reset
//   DEBOUNCE_PULSE           - one-cycle sample strobe
//   HALF_SEC_PULSE           - one-cycle 0.5 s strobe
//   BTN_*                    - raw asynchronous buttons
//   DEBOUNCED_M_INPUT/S_INPUT- one-cycle pulse per press or repeat
//   DEBOUNCED_START/STOP     - one-cycle pulse per press (STOP wins ties)
//   DEBOUNCED_UP_DOWN        - level toggled per press, 0 = count down
module button_debouncer
  import kt_pkg::*;
#(
  parameter int unsigned STABLE_SAMPLES = 3,
  parameter int unsigned REPEAT_DELAY   = 2,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input  logic CLK,
  input  logic RES,
  input  logic DEBOUNCE_PULSE,
  input  logic HALF_SEC_PULSE,
  input  logic BTN_M,
  input  logic BTN_S,
  input  logic BTN_START,
  input  logic BTN_STOP,
  input  logic BTN_UP_DOWN,
  output logic DEBOUNCED_M_INPUT,
  output logic DEBOUNCED_S_INPUT,
  output logic DEBOUNCED_START,
  output logic DEBOUNCED_STOP,
  output logic DEBOUNCED_UP_DOWN
);

`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
  localparam bit AR_EN = 1'b1;
`else
  localparam bit AR_EN = 1'b0;
`endif

  logic m_press, m_rep, s_press, s_rep;
  logic start_press, start_rep, stop_press, stop_rep, ud_press, ud_rep;

  debounce_channel #(
    .STABLE_SAMPLES(STABLE_SAMPLES), .REPEAT_DELAY(REPEAT_DELAY),
    .ACTIVE_LOW(BTN_ACTIVE_LOW), .REPEAT_EN(AR_EN)
  ) u_m (
    .clk(CLK), .res(RES), .tick(DEBOUNCE_PULSE), .half_tick(HALF_SEC_PULSE),
    .btn(BTN_M), .press_evt(m_press), .repeat_evt(m_rep)
  );

  debounce_channel #(
    .STABLE_SAMPLES(STABLE_SAMPLES), .REPEAT_DELAY(REPEAT_DELAY),
    .ACTIVE_LOW(BTN_ACTIVE_LOW), .REPEAT_EN(AR_EN)
  ) u_s (
    .clk(CLK), .res(RES), .tick(DEBOUNCE_PULSE), .half_tick(HALF_SEC_PULSE),
    .btn(BTN_S), .press_evt(s_press), .repeat_evt(s_rep)
  );

  debounce_channel #(
    .STABLE_SAMPLES(STABLE_SAMPLES), .REPEAT_DELAY(REPEAT_DELAY),
    .ACTIVE_LOW(BTN_ACTIVE_LOW), .REPEAT_EN(1'b0)
  ) u_start (
    .clk(CLK), .res(RES), .tick(DEBOUNCE_PULSE), .half_tick(HALF_SEC_PULSE),
    .btn(BTN_START), .press_evt(start_press), .repeat_evt(start_rep)
  );

  debounce_channel #(
    .STABLE_SAMPLES(STABLE_SAMPLES), .REPEAT_DELAY(REPEAT_DELAY),
    .ACTIVE_LOW(BTN_ACTIVE_LOW), .REPEAT_EN(1'b0)
  ) u_stop (
    .clk(CLK), .res(RES), .tick(DEBOUNCE_PULSE), .half_tick(HALF_SEC_PULSE),
    .btn(BTN_STOP), .press_evt(stop_press), .repeat_evt(stop_rep)
  );

  debounce_channel #(
    .STABLE_SAMPLES(STABLE_SAMPLES), .REPEAT_DELAY(REPEAT_DELAY),
    .ACTIVE_LOW(BTN_ACTIVE_LOW), .REPEAT_EN(1'b0)
  ) u_ud (
    .clk(CLK), .res(RES), .tick(DEBOUNCE_PULSE), .half_tick(HALF_SEC_PULSE),
    .btn(BTN_UP_DOWN), .press_evt(ud_press), .repeat_evt(ud_rep)
  );

  logic unused_rep;
  assign unused_rep = ^{start_rep, stop_rep, ud_rep};

  // Output registers; a coincident press and repeat yield a single pulse.
  always_ff @(posedge CLK) begin
    if (RES) begin
      DEBOUNCED_M_INPUT <= 1'b0;
      DEBOUNCED_S_INPUT <= 1'b0;
      DEBOUNCED_START   <= 1'b0;
      DEBOUNCED_STOP    <= 1'b0;
      DEBOUNCED_UP_DOWN <= 1'b0;
    end else begin
      DEBOUNCED_M_INPUT <= m_press | m_rep;
      DEBOUNCED_S_INPUT <= s_press | s_rep;
      DEBOUNCED_START   <= start_press & ~stop_press;
      DEBOUNCED_STOP    <= stop_press;
      DEBOUNCED_UP_DOWN <= DEBOUNCED_UP_DOWN ^ ud_press;
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer (STABLE_SAMPLES=3, REPEAT_DELAY=2,
// active-low buttons). Stimulus pushes expected {output mask, cycle}; a
// negedge monitor pops and compares whenever any pulse or UP_DOWN edge shows.
module tb_button_debouncer;

  localparam logic [4:0] E_NONE  = 5'b00000;
  localparam logic [4:0] E_M     = 5'b00001;
  localparam logic [4:0] E_S     = 5'b00010;
  localparam logic [4:0] E_START = 5'b00100;
  localparam logic [4:0] E_STOP  = 5'b01000;
  localparam logic [4:0] E_UD    = 5'b10000;

  typedef struct {
    logic [4:0] mask;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic res = 1'b1;
  logic dp = 1'b0;
  logic hp = 1'b0;
  logic btn_m = 1'b1, btn_s = 1'b1, btn_start = 1'b1, btn_stop = 1'b1, btn_ud = 1'b1;
  logic out_m, out_s, out_start, out_stop, out_ud;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  logic ud_prev = 1'b0;

  button_debouncer #(
    .STABLE_SAMPLES(3), .REPEAT_DELAY(2), .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .CLK(clk), .RES(res), .DEBOUNCE_PULSE(dp), .HALF_SEC_PULSE(hp),
    .BTN_M(btn_m), .BTN_S(btn_s), .BTN_START(btn_start), .BTN_STOP(btn_stop),
    .BTN_UP_DOWN(btn_ud),
    .DEBOUNCED_M_INPUT(out_m), .DEBOUNCED_S_INPUT(out_s),
    .DEBOUNCED_START(out_start), .DEBOUNCED_STOP(out_stop),
    .DEBOUNCED_UP_DOWN(out_ud)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any pulse or UP_DOWN edge must match the head of the queue.
  always @(negedge clk) begin
    logic [4:0] obs;
    exp_t       e;
    obs = {out_ud != ud_prev, out_stop, out_start, out_s, out_m};
    ud_prev = out_ud;
    if (obs != E_NONE) begin
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL pulse_unexpected: got mask %b at cycle %0d, expected none", obs, cyc);
      end else begin
        e = q.pop_front();
        if (obs !== e.mask || cyc != e.cyc) begin
          fails++;
          $display("FAIL pulse_event: got mask %b at cycle %0d, expected mask %b at cycle %0d",
                   obs, cyc, e.mask, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Debounce strobe; the resulting pulse is due in the following cycle.
  task automatic tick(input logic [4:0] exp_mask);
    repeat (3) @(negedge clk);
    dp = 1'b1;
    if (exp_mask != E_NONE) q.push_back('{exp_mask, cyc + 1});
    @(negedge clk);
    dp = 1'b0;
  endtask

  task automatic half(input logic [4:0] exp_mask);
    repeat (3) @(negedge clk);
    hp = 1'b1;
    if (exp_mask != E_NONE) q.push_back('{exp_mask, cyc + 1});
    @(negedge clk);
    hp = 1'b0;
  endtask

  task automatic release_all();
    {btn_m, btn_s, btn_start, btn_stop, btn_ud} = 5'b11111;
    for (int i = 0; i < 3; i++) tick(E_NONE);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    check("reset_outputs", {27'd0, out_ud, out_stop, out_start, out_s, out_m}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    res = 1'b0;
    check("reset_state", {27'd0, out_ud, out_stop, out_start, out_s, out_m}, 32'd0);

    // Clean START press held for 5 ticks: one pulse after tick 3.
    btn_start = 1'b0;
    for (int i = 1; i <= 5; i++) tick(i == 3 ? E_START : E_NONE);
    release_all();

    // M press bounce: 2 pressed, 1 released, 4 pressed -> pulse at tick 6.
    btn_m = 1'b0; tick(E_NONE); tick(E_NONE);
    btn_m = 1'b1; tick(E_NONE);
    btn_m = 1'b0;
    for (int i = 4; i <= 7; i++) tick(i == 6 ? E_M : E_NONE);
    release_all();

    // S release bounce: no second pulse, ends in IDLE (fresh press qualifies).
    btn_s = 1'b0;
    for (int i = 1; i <= 3; i++) tick(i == 3 ? E_S : E_NONE);
    btn_s = 1'b1; tick(E_NONE);
    btn_s = 1'b0; tick(E_NONE); tick(E_NONE);
    btn_s = 1'b1; for (int i = 0; i < 3; i++) tick(E_NONE);
    btn_s = 1'b0;
    for (int i = 1; i <= 3; i++) tick(i == 3 ? E_S : E_NONE);
    release_all();

    // UP_DOWN toggles 0 -> 1 -> 0.
    btn_ud = 1'b0;
    for (int i = 1; i <= 3; i++) tick(i == 3 ? E_UD : E_NONE);
    release_all();
    check("up_down_first", {31'd0, out_ud}, 32'd1);
    btn_ud = 1'b0;
    for (int i = 1; i <= 3; i++) tick(i == 3 ? E_UD : E_NONE);
    release_all();
    check("up_down_second", {31'd0, out_ud}, 32'd0);

    // START and STOP qualify together: only STOP pulses.
    btn_start = 1'b0; btn_stop = 1'b0;
    for (int i = 1; i <= 3; i++) tick(i == 3 ? E_STOP : E_NONE);
    release_all();

    // Reset while STOP held in PRESSED, then release and press again.
    btn_stop = 1'b0;
    for (int i = 1; i <= 4; i++) tick(i == 3 ? E_STOP : E_NONE);
    pulse_reset();
    btn_stop = 1'b1; tick(E_NONE); tick(E_NONE);
    btn_stop = 1'b0;
    for (int i = 1; i <= 3; i++) tick(i == 3 ? E_STOP : E_NONE);
    release_all();

    // Button held across reset is re-qualified from IDLE.
    btn_m = 1'b0;
    for (int i = 1; i <= 3; i++) tick(i == 3 ? E_M : E_NONE);
    pulse_reset();
    for (int i = 1; i <= 3; i++) tick(i == 3 ? E_M : E_NONE);
    release_all();

    // No sample strobes: held button never qualifies.
    btn_s = 1'b0;
    repeat (30) @(negedge clk);
    check("idle_strobe_quiet", {27'd0, out_ud, out_stop, out_start, out_s, out_m}, 32'd0);
    btn_s = 1'b1;
    repeat (5) @(negedge clk);

    // M held through 5 half-second ticks after qualification.
    btn_m = 1'b0;
    for (int i = 1; i <= 3; i++) tick(i == 3 ? E_M : E_NONE);
    for (int h = 1; h <= 5; h++) begin
`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
      half(h >= 3 ? E_M : E_NONE);
`else
      half(E_NONE);
`endif
    end
    release_all();

    repeat (10) @(negedge clk);
    check("queue_drained", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
